simulaciones: RTL and testbench



---
 rtl/simulaciones_pkg.sv | 18 +
 rtl/simulaciones_sync_bit.sv | 20 ++
 rtl/simulaciones.sv | 142 ++++++++++++++
 tb/tb_simulaciones.sv | 130 +++++++++++++
 4 files changed

// File: rtl/simulaciones_pkg.sv
// Shared command codes and motor-state type for the home-automation controller.
package simulaciones_pkg;

  localparam logic [3:0] CMD_LIGHT_ON  = 4'h1;
  localparam logic [3:0] CMD_LIGHT_OFF = 4'h2;
  localparam logic [3:0] CMD_OPEN      = 4'h3;
  localparam logic [3:0] CMD_CLOSE     = 4'h4;
  localparam logic [3:0] CMD_STOP      = 4'h5;
  localparam logic [3:0] CMD_ARM       = 4'h6;
  localparam logic [3:0] CMD_DISARM    = 4'h7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2
  } motor_state_t;

endpackage

// File: rtl/simulaciones_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer, async active-high reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/simulaciones.sv
// Home-automation controller core: light, alarm latch and door motor FSM.
// Optional night light enabled by defining SIMULACIONES_NIGHT_LIGHT_EN.
module simulaciones
  import simulaciones_pkg::*;
#(
  parameter int MOTOR_TIMEOUT = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] RxData,
  input  logic       FinalCarrera1,
  input  logic       FinalCarrera2,
  input  logic       LuzSwitch,
  input  logic       Sensor,
  input  logic       clockLight,
  output logic       Luz,
  output logic       Alarma,
  output logic       Motor1,
  output logic       Motor2
);

  localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int NUM_IN = 8;
  localparam int TLIM   = (MOTOR_TIMEOUT > 0) ? MOTOR_TIMEOUT - 1 : 0;
  localparam int CW     = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;

  logic [NUM_IN-1:0] raw, syn;
  assign raw = {LuzSwitch, Sensor, FinalCarrera2, FinalCarrera1, RxData};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
    sync_bit #(.STAGES(SS)) u_sync (.clk(clk), .rst(rst), .d(raw[i]), .q(syn[i]));
  end

  logic [3:0] rx;
  logic       fc1, fc2, sensor, sw, night;
  assign rx     = syn[3:0];
  assign fc1    = syn[4];
  assign fc2    = syn[5];
  assign sensor = syn[6];
  assign sw     = syn[7];

`ifdef SIMULACIONES_NIGHT_LIGHT_EN
  logic dark;
  sync_bit #(.STAGES(SS)) u_sync_dark (.clk(clk), .rst(rst), .d(clockLight), .q(dark));
  assign night = dark & sensor;
`else
  logic unused_night;
  assign unused_night = clockLight;
  assign night        = 1'b0;
`endif

  logic [3:0]   rx_prev;
  logic         light, armed;
  motor_state_t state, pend;
  logic [CW-1:0] cnt;

  // A command fires only on the cycle the synchronized code changes.
  logic cmd_new, c_on, c_off, c_open, c_close, c_stop, c_arm, c_disarm;
  assign cmd_new  = (rx != rx_prev);
  assign c_on     = cmd_new && (rx == CMD_LIGHT_ON);
  assign c_off    = cmd_new && (rx == CMD_LIGHT_OFF);
  assign c_open   = cmd_new && (rx == CMD_OPEN);
  assign c_close  = cmd_new && (rx == CMD_CLOSE);
  assign c_stop   = cmd_new && (rx == CMD_STOP);
  assign c_arm    = cmd_new && (rx == CMD_ARM);
  assign c_disarm = cmd_new && (rx == CMD_DISARM);

  logic fault, timeout, light_nx;
  motor_state_t state_nx, pend_nx;
  logic [CW-1:0] cnt_nx;

  assign fault   = fc1 & fc2;
  assign timeout = (MOTOR_TIMEOUT != 0) && (cnt == CW'(TLIM));

  always_comb begin
    light_nx = light;
    if (c_on)  light_nx = 1'b1;
    if (c_off) light_nx = 1'b0;

    state_nx = state;
    pend_nx  = IDLE;
    unique case (state)
      IDLE: if (!fault) begin
        if      (c_open  && !fc1)            state_nx = OPENING;
        else if (c_close && !fc2)            state_nx = CLOSING;
        else if (pend == OPENING && !fc1)    state_nx = OPENING;
        else if (pend == CLOSING && !fc2)    state_nx = CLOSING;
      end
      // A reversal parks in IDLE for one cycle and remembers the new direction.
      OPENING: begin
        if (fault || fc1 || c_stop || timeout) state_nx = IDLE;
        else if (c_close) begin
          state_nx = IDLE;
          pend_nx  = CLOSING;
        end
      end
      CLOSING: begin
        if (fault || fc2 || c_stop || timeout) state_nx = IDLE;
        else if (c_open) begin
          state_nx = IDLE;
          pend_nx  = OPENING;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx != state)      cnt_nx = '0;
    else if (cnt == CW'(TLIM))  cnt_nx = cnt;
    else                        cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= '0;
      light   <= 1'b0;
      armed   <= 1'b0;
      state   <= IDLE;
      pend    <= IDLE;
      cnt     <= '0;
      Luz     <= 1'b0;
      Alarma  <= 1'b0;
      Motor1  <= 1'b0;
      Motor2  <= 1'b0;
    end else begin
      rx_prev <= rx;
      light   <= light_nx;
      state   <= state_nx;
      pend    <= pend_nx;
      cnt     <= cnt_nx;
      if (c_arm)    armed <= 1'b1;
      if (c_disarm) armed <= 1'b0;
      // Latch uses the current armed bit, so arming under detection trips a cycle later.
      if (c_disarm)           Alarma <= 1'b0;
      else if (armed & sensor) Alarma <= 1'b1;
      Luz    <= light_nx | sw | night;
      Motor1 <= (state_nx == OPENING);
      Motor2 <= (state_nx == CLOSING);
    end
  end

endmodule

// File: tb/tb_simulaciones.sv
// Directed self-checking bench for simulaciones (MOTOR_TIMEOUT=10, default sync depth).
module tb_simulaciones;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] RxData;
  logic       FinalCarrera1, FinalCarrera2, LuzSwitch, Sensor, clockLight;
  logic       Luz, Alarma, Motor1, Motor2;

  int tests = 0;
  int fails = 0;

  simulaciones #(.MOTOR_TIMEOUT(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .RxData(RxData),
    .FinalCarrera1(FinalCarrera1), .FinalCarrera2(FinalCarrera2),
    .LuzSwitch(LuzSwitch), .Sensor(Sensor), .clockLight(clockLight),
    .Luz(Luz), .Alarma(Alarma), .Motor1(Motor1), .Motor2(Motor2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1ns after each edge; motors must never both drive.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("motor_excl", Motor1 & Motor2, 1'b0);
    end
  endtask

  task automatic send(input logic [3:0] c);
    RxData = c;
    step(3);
  endtask

  initial begin
    rst = 1'b1; RxData = 4'h0; FinalCarrera1 = 0; FinalCarrera2 = 0;
    LuzSwitch = 0; Sensor = 0; clockLight = 0;
    #1;
    check("rst_luz", Luz, 1'b0);
    check("rst_alarma", Alarma, 1'b0);
    check("rst_m1", Motor1, 1'b0);
    check("rst_m2", Motor2, 1'b0);
    step(2);
    rst = 1'b0;
    step(3);

    // Light: 3-cycle latency, off command, wall switch override
    RxData = 4'h1;
    step(2); check("luz_latency_early", Luz, 1'b0);
    step(1); check("luz_on", Luz, 1'b1);
    send(4'h2); check("luz_off", Luz, 1'b0);
    LuzSwitch = 1; step(3); check("switch_on", Luz, 1'b1);
    send(4'h1); check("switch_cmd_on", Luz, 1'b1);
    send(4'h2); check("switch_cmd_off", Luz, 1'b1);
    LuzSwitch = 0; step(3); check("switch_release", Luz, 1'b0);
    send(4'h1); check("luz_on2", Luz, 1'b1);
    step(20); check("luz_hold", Luz, 1'b1);

    // Alarm
    send(4'h6); check("armed_quiet", Alarma, 1'b0);
    Sensor = 1; step(3); check("alarm_trip", Alarma, 1'b1);
    Sensor = 0; step(5); check("alarm_latched", Alarma, 1'b1);
    send(4'h7); check("alarm_disarm", Alarma, 1'b0);
    Sensor = 1; step(4); check("disarmed_sensor", Alarma, 1'b0);
    send(4'h6); check("arm_under_sensor_early", Alarma, 1'b0);
    step(1); check("arm_under_sensor", Alarma, 1'b1);
    Sensor = 0; send(4'h7); check("alarm_clear2", Alarma, 1'b0);

    // Open, stop at limit, no restart when open or when code is held
    send(4'h3); check("open_m1", Motor1, 1'b1); check("open_m2", Motor2, 1'b0);
    FinalCarrera1 = 1;
    step(2); check("limit_early", Motor1, 1'b1);
    step(1); check("limit_stop", Motor1, 1'b0);
    send(4'h0); send(4'h3); check("open_when_open", Motor1, 1'b0);
    FinalCarrera1 = 0; step(4); check("held_no_reexec", Motor1, 1'b0);

    // Reversal through one IDLE cycle
    send(4'h4); check("close_m2", Motor2, 1'b1);
    RxData = 4'h3;
    step(2); check("rev_still_closing", Motor2, 1'b1);
    step(1); check("rev_idle_m1", Motor1, 1'b0); check("rev_idle_m2", Motor2, 1'b0);
    step(1); check("rev_opening", Motor1, 1'b1);
    send(4'h5); check("stop_cmd", Motor1, 1'b0);

    // Timeout of 10 cycles
    send(4'h4); check("to_start", Motor2, 1'b1);
    step(9); check("to_before", Motor2, 1'b1);
    step(1); check("to_expired", Motor2, 1'b0);

    // Both limits active: no start accepted
    FinalCarrera1 = 1; FinalCarrera2 = 1;
    send(4'h0);
    send(4'h3); check("fault_no_open", Motor1, 1'b0);
    send(4'h4); check("fault_no_close", Motor2, 1'b0);
    FinalCarrera1 = 0; FinalCarrera2 = 0;
    step(3); check("fault_clear_held", Motor2, 1'b0);

    // Reserved codes do nothing
    send(4'h1);
    for (int c = 8; c < 16; c++) begin
      send(4'(c));
      check("nop_luz", Luz, 1'b1);
      check("nop_alarma", Alarma, 1'b0);
      check("nop_m1", Motor1, 1'b0);
      check("nop_m2", Motor2, 1'b0);
    end

    // Asynchronous reset mid-motion
    send(4'h3); check("pre_rst_m1", Motor1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_m1", Motor1, 1'b0);
    check("async_rst_m2", Motor2, 1'b0);
    check("async_rst_luz", Luz, 1'b0);
    check("async_rst_alarma", Alarma, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
